lif_neuron_fp32: RTL
====================

# lif_neuron_fp32

Sequential leaky integrate-and-fire neuron built around the team's combinational FP32 `ADDER` (ports `A`, `B`, `SUM`). It integrates one timestep at a time: the spike vector arrives on a valid/ready handshake, and the block adds one synaptic weight per cycle through a single `ADDER` instance. It then applies a constant leak, compares the membrane potential to a threshold, and emits an output spike. The block sits directly downstream of the adder, consuming its sum every cycle, and feeds the next layer's spike vector.

## Interface
- `N_INPUTS`, 16: synapses per neuron; must be ≥ 2.
- `THRESHOLD`, 32'h3F800000 (1.0): firing threshold, IEEE-754 single; must be positive and finite.
- `LEAK_NEG`, 32'hBD4CCCCD (−0.05): leak added once per timestep; must be negative or zero.
- `V_RESET`, 32'h00000000: membrane value after a spike or a NaN.
- `ADDR_W`, $clog2(N_INPUTS): weight address width (derived).

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `IN_VALID` in 1: spike vector valid.
- `IN_READY` out 1: block can accept a vector.
- `SPIKE_IN` in N_INPUTS: input spikes; bit i selects weight i.
- `WEIGHT_ADDR` out ADDR_W: weight index, driven to the weight memory.
- `WEIGHT_DATA` in 32: weight at `WEIGHT_ADDR`, asynchronous read, valid in the same cycle.
- `OUT_VALID` out 1: one-cycle pulse marking a completed timestep.
- `SPIKE_OUT` out 1: fire result, meaningful while `OUT_VALID` = 1.
- `V_MEM` out 32: membrane register, always visible.

## Operation
- Reset (asynchronous, `RST_N` = 0):
  - `V_MEM` = 32'h0.
  - State = IDLE, index = 0, latched spikes = 0.
  - `OUT_VALID` = 0, `SPIKE_OUT` = 0, `WEIGHT_ADDR` = 0, `IN_READY` = 1 (combinational from state).
- `ADDER` wiring: one instance; `A` = `V_MEM`; `B` = `WEIGHT_DATA` in ACCUM, `LEAK_NEG` in LEAK.
- IDLE:
  - `IN_READY` = 1.
  - On `IN_VALID` & `IN_READY`: latch `SPIKE_IN`, clear the index, go to ACCUM.
  - `V_MEM` holds.
- ACCUM (`IN_READY` = 0):
  - `WEIGHT_ADDR` = index.
  - If latched bit[index] = 1, `V_MEM` ← `SUM`; otherwise `V_MEM` holds.
  - Index increments by 1. When index = N_INPUTS−1, go to LEAK. The index never wraps inside a timestep.
- LEAK: `V_MEM` ← `SUM` (= `V_MEM` + `LEAK_NEG`); go to FIRE.
- FIRE: evaluate the membrane, then go to IDLE.
  - NaN (exp = FF, mantissa ≠ 0): `SPIKE_OUT` ← 0, `V_MEM` ← `V_RESET`.
  - Fire condition: sign = 0 and `V_MEM`[30:0] ≥ `THRESHOLD`[30:0]. This is an unsigned magnitude compare, so +Inf fires and any negative value does not.
  - If fire: `SPIKE_OUT` ← 1, `V_MEM` ← `V_RESET`. Else: `SPIKE_OUT` ← 0, `V_MEM` holds.
  - `OUT_VALID` ← 1.
- `OUT_VALID` is registered and cleared on the next edge. `SPIKE_OUT` holds its value until the next FIRE.
- `IN_VALID` is ignored outside IDLE. The upstream block must hold `SPIKE_IN` stable only on the handshake edge.
- `WEIGHT_DATA` is ignored outside ACCUM.
- Negative potentials are kept (no floor clamp).

## Timing
- Handshake edge = edge 0.
  - ACCUM occupies edges 1..N_INPUTS.
  - LEAK is edge N_INPUTS+1.
  - FIRE is edge N_INPUTS+2.
- `OUT_VALID` is high for exactly one cycle, following edge N_INPUTS+2.
- Latency from handshake to `OUT_VALID` = N_INPUTS+2 edges. Throughput = one timestep per N_INPUTS+3 cycles.
- `IN_READY` rises in the same cycle `OUT_VALID` is high, so a new vector may be accepted on the edge that ends the `OUT_VALID` pulse (back-to-back).
- Each add is one `ADDER` evaluation per cycle. The combinational path runs from `V_MEM`/`WEIGHT_DATA` through `ADDER` to the `V_MEM` D-input and must close in one clock period.
- A reset asserted mid-ACCUM, LEAK or FIRE aborts the timestep immediately. No `OUT_VALID` is produced, and all outputs return to their reset values asynchronously.
- `RST_N` deassertion is synchronised externally. The first handshake is legal on the first edge after release.

## Test plan
Parameters for all scenarios: N_INPUTS=4, THRESHOLD=1.0, LEAK_NEG=32'hBE800000 (−0.25), all weights 32'h3F000000 (0.5) unless stated.

1. Reset pulse mid-ACCUM (second vector) → `V_MEM`=0, `OUT_VALID`=0, `SPIKE_OUT`=0, `IN_READY`=1 during reset, no `OUT_VALID` afterward. Then a fresh timestep with `SPIKE_IN`=4'b0000 completes normally.
2. From reset, two steps with `SPIKE_IN`=4'b0011:
   - Step 1: `OUT_VALID` pulses 6 edges after the handshake, `SPIKE_OUT`=0, `V_MEM`=32'h3F400000 (0.75).
   - Step 2 (back-to-back, `IN_VALID` held high): `SPIKE_OUT`=1, `V_MEM`=0. Confirms the 7-cycle period.
3. From 0, `SPIKE_IN`=4'b1111 → sum 2.0 − 0.25 = 1.75 ≥ 1.0, `SPIKE_OUT`=1, `V_MEM`=0. Check `WEIGHT_ADDR` sequences 0,1,2,3 in ACCUM.
4. From 0, `SPIKE_IN`=4'b0000 → `V_MEM`=32'hBE800000, `SPIKE_OUT`=0. Follow with `SPIKE_IN`=4'b0001 and weight 32'h3FA00000 (1.25) → 1.25 − 0.25 − 0.25 = 0.75, no spike.
5. `IN_VALID` toggled and `SPIKE_IN` changed during ACCUM → no effect on the result, `IN_READY`=0 throughout ACCUM/LEAK/FIRE.
6. Weight 0 = 32'h7FC00000 (NaN), `SPIKE_IN`=4'b0001 → `SPIKE_OUT`=0, `V_MEM`=`V_RESET`. Weight 0 = 32'h7F800000 (+Inf) → `SPIKE_OUT`=1, `V_MEM`=`V_RESET`.

Source files
------------

// File: rtl/lif_neuron_fp32.sv
// ---------------------------------------------------------------------------
// ADDER
//   Combinational IEEE-754 single-precision adder, round-to-nearest-even.
//   Handles zeros, subnormals, infinities and NaN (canonical quiet NaN out).
//   A, B : operands
//   SUM  : A + B
// ---------------------------------------------------------------------------
module ADDER (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] SUM
);

  logic        a_nan, b_nan, a_inf, b_inf;
  logic        swap, eff_sub, sticky, round_up;
  logic [31:0] big, sml;
  logic [7:0]  e_big, e_sml, dexp;
  logic [26:0] m_big, m_sml, m_sh;
  logic [27:0] raw;
  logic [26:0] norm;
  logic [4:0]  lz, shamt;
  logic [9:0]  e_res;
  logic [7:0]  e_field;
  logic [30:0] packed_res;

  always_comb begin
    a_nan      = (A[30:23] == 8'hFF) && (A[22:0] != 23'd0);
    b_nan      = (B[30:23] == 8'hFF) && (B[22:0] != 23'd0);
    a_inf      = (A[30:23] == 8'hFF) && (A[22:0] == 23'd0);
    b_inf      = (B[30:23] == 8'hFF) && (B[22:0] == 23'd0);
    shamt      = 5'd0;
    norm       = 27'd0;
    e_res      = 10'd0;
    lz         = 5'd0;

    // Order by magnitude so the aligned subtraction never goes negative.
    swap       = B[30:0] > A[30:0];
    big        = swap ? B : A;
    sml        = swap ? A : B;
    // Subnormals share the exponent of the smallest normal, without hidden bit.
    e_big      = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
    e_sml      = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
    m_big      = {(big[30:23] != 8'd0), big[22:0], 3'b000};
    m_sml      = {(sml[30:23] != 8'd0), sml[22:0], 3'b000};
    dexp       = e_big - e_sml;

    // Three extra low bits (guard, round, sticky); shifted-out bits fold into bit 0.
    if (dexp >= 8'd27) begin
      m_sh   = 27'd0;
      sticky = |m_sml;
    end else begin
      m_sh   = m_sml >> dexp;
      sticky = |(m_sml & ~({27{1'b1}} << dexp));
    end
    m_sh[0]    = m_sh[0] | sticky;

    eff_sub    = big[31] ^ sml[31];
    raw        = eff_sub ? ({1'b0, m_big} - {1'b0, m_sh})
                         : ({1'b0, m_big} + {1'b0, m_sh});

    for (int i = 0; i < 27; i++) begin
      if (raw[i]) lz = 5'(26 - i);
    end

    if (raw[27]) begin
      norm  = {raw[27:2], raw[1] | raw[0]};
      e_res = {2'b00, e_big} + 10'd1;
    end else begin
      // Stop normalising at the subnormal boundary.
      shamt = (8'(lz) <= (e_big - 8'd1)) ? lz : 5'(e_big - 8'd1);
      norm  = raw[26:0] << shamt;
      e_res = {2'b00, e_big} - {5'd0, shamt};
    end

    e_field    = norm[26] ? e_res[7:0] : 8'd0;
    round_up   = norm[2] & (norm[3] | norm[1] | norm[0]);
    // Rounding carry ripples naturally into the exponent field.
    packed_res = {e_field, norm[25:3]} + {30'd0, round_up};

    if (a_nan || b_nan || (a_inf && b_inf && (A[31] ^ B[31])))
      SUM = 32'h7FC00000;
    else if (a_inf)
      SUM = A;
    else if (b_inf)
      SUM = B;
    else if (raw == 28'd0)
      SUM = {A[31] & B[31], 31'd0};
    else if (e_res >= 10'd255)
      SUM = {big[31], 8'hFF, 23'd0};
    else
      SUM = {big[31], packed_res};
  end

endmodule

// ---------------------------------------------------------------------------
// lif_neuron_fp32
//   Leaky integrate-and-fire neuron, FP32 membrane. One synaptic add per
//   cycle through a single ADDER, then one leak add, then threshold/fire.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | ready for a spike vector, membrane holds
//   ACCUM  | add weight[idx] when latched spike[idx] is set, idx 0..N-1
//   LEAK   | membrane += LEAK_NEG
//   FIRE   | NaN/threshold check, pulse OUT_VALID, optionally reset
//
//   CLK, RST_N           : clock, async active-low reset
//   IN_VALID / IN_READY  : spike-vector handshake
//   SPIKE_IN             : input spike vector
//   WEIGHT_ADDR/DATA     : weight memory port (async read)
//   OUT_VALID, SPIKE_OUT : timestep done pulse and fire result
//   V_MEM                : membrane register
// ---------------------------------------------------------------------------
module lif_neuron_fp32 #(
  parameter int          N_INPUTS  = 16,
  parameter logic [31:0] THRESHOLD = 32'h3F800000,
  parameter logic [31:0] LEAK_NEG  = 32'hBD4CCCCD,
  parameter logic [31:0] V_RESET   = 32'h00000000,
  localparam int         ADDR_W    = $clog2(N_INPUTS)
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [N_INPUTS-1:0] SPIKE_IN,
  output logic [ADDR_W-1:0]   WEIGHT_ADDR,
  input  logic [31:0]         WEIGHT_DATA,
  output logic                OUT_VALID,
  output logic                SPIKE_OUT,
  output logic [31:0]         V_MEM
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_LEAK, S_FIRE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_INPUTS - 1);

  state_t              state;
  logic [ADDR_W-1:0]   idx;
  logic [N_INPUTS-1:0] spikes;
  logic [31:0]         v_mem;
  logic                out_valid, spike_out;
  logic [31:0]         add_b, sum;
  logic                is_nan, fires;

  assign add_b = (state == S_ACCUM) ? WEIGHT_DATA : LEAK_NEG;

  ADDER u_adder (
    .A   (v_mem),
    .B   (add_b),
    .SUM (sum)
  );

  assign is_nan = (v_mem[30:23] == 8'hFF) && (v_mem[22:0] != 23'd0);
  // Sign/magnitude compare on raw bits: +Inf fires, negatives never do.
  assign fires  = !v_mem[31] && (v_mem[30:0] >= THRESHOLD[30:0]);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      idx       <= '0;
      spikes    <= '0;
      v_mem     <= '0;
      out_valid <= 1'b0;
      spike_out <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (IN_VALID) begin
            spikes <= SPIKE_IN;
            idx    <= '0;
            state  <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (spikes[idx]) v_mem <= sum;
          // Index parks at the last synapse rather than wrapping.
          if (idx == LAST_IDX) state <= S_LEAK;
          else                 idx   <= idx + ADDR_W'(1);
        end
        S_LEAK: begin
          v_mem <= sum;
          state <= S_FIRE;
        end
        S_FIRE: begin
          out_valid <= 1'b1;
          state     <= S_IDLE;
          if (is_nan) begin
            spike_out <= 1'b0;
            v_mem     <= V_RESET;
          end else if (fires) begin
            spike_out <= 1'b1;
            v_mem     <= V_RESET;
          end else begin
            spike_out <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign IN_READY    = (state == S_IDLE);
  assign WEIGHT_ADDR = idx;
  assign OUT_VALID   = out_valid;
  assign SPIKE_OUT   = spike_out;
  assign V_MEM       = v_mem;

endmodule
